mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single unified memory port of the multicycle core between two requesters: the core
// (instruction fetch and load/store, port C) and a DMA/debug master (port D).
// - Round-robin arbitration; one outstanding transaction at a time.
// - Variable-latency memory handshake with a wait-state timeout.
// - Sits between the core's memory address/write mux and the memory; the controller stalls until c_ack.
// PARAMETERS
// ADDR_W   32   address width
// DATA_W   32   data width
// TIMEOUT  255  max ACCESS cycles before an error response; 0 disables the timeout
// PORTS
// clk        in   1       clock
// rst        in   1       asynchronous, active-low reset
// c_req      in   1       core request; held until c_ack
// c_we       in   1       core write enable
// c_addr     in   ADDR_W  core address
// c_wdata    in   DATA_W  core write data
// c_ack      out  1       one-cycle completion pulse to core
// c_err      out  1       core transaction timed out; valid with c_ack
// d_req/d_we/d_addr/d_wdata/d_ack/d_err   same as the c_* ports, for the DMA port
// rdata      out  DATA_W  read data, valid while c_ack or d_ack is high
// mem_valid  out  1       memory access active
// mem_we     out  1       memory write
// mem_addr   out  ADDR_W  memory address
// mem_wdata  out  DATA_W  memory write data
// mem_ready  in   1       memory completes the access this cycle
// mem_rdata  in   DATA_W  memory read data, valid with mem_ready
// owner      out  1       current/last grant: 0 = core, 1 = DMA
// busy       out  1       state != IDLE
// BEHAVIOUR
// - Reset values: all outputs 0; state = IDLE; wait_cnt = 0; last_grant = 1 (core wins the first tie).
// - FSM has three states: IDLE, ACCESS, RESP.
// IDLE:
// - Samples the requests.
// - Only one request high -> grant it.
// - Both high -> grant the port != last_grant.
// - On grant, register we/addr/wdata of the winner, set owner and last_grant, then go to ACCESS.
// - No request -> stay in IDLE.
// ACCESS:
// - mem_valid = 1; mem_we/addr/wdata are driven from the captured registers, stable for the whole access.
// - wait_cnt increments each cycle.
// - mem_ready = 1 -> latch mem_rdata into rdata, err_q = 0, go to RESP.
// - TIMEOUT != 0 and wait_cnt == TIMEOUT-1 without mem_ready -> err_q = 1, rdata = 0, go to RESP.
// RESP:
// - mem_valid = 0; pulse the owner's ack for exactly one cycle.
// - The owner's err = err_q; the other port's ack/err stay 0.
// - Clear wait_cnt and go to IDLE.
// Latency and requester rule:
// - Minimum latency is req at cycle N (IDLE), ACCESS at N+1 with mem_ready, ack at N+2.
// - The next grant is possible at N+3.
// - A requester must drop req on the clock edge where it samples ack = 1.
// - A req still high in IDLE is a new transaction.
// Boundaries:
// - req dropped during ACCESS: ignored; the transaction completes and is still acked.
// - Request inputs changing after the grant: no effect, because the captured registers are used.
// - mem_ready while in IDLE or RESP: ignored.
// - Fairness: back-to-back requests from both ports alternate C, D, C, D.
// - Asynchronous reset mid-ACCESS: mem_valid falls immediately, no ack is issued, and the reset values apply.
// - Writes return rdata = 0.
// STRUCTURE
// - Shared include file (alongside the existing select/opcode defines):
//   - ARB_IDLE/ARB_ACCESS/ARB_RESP state encodings (2-bit).
//   - OWNER_CORE = 1'b0, OWNER_DMA = 1'b1.
// - Sub-module rr_pick2: combinational; inputs req[1:0] and last_grant; outputs grant_valid and grant_id.
// - FSM, capture registers and wait counter stay in mem_port_arbiter.
// TESTING
// 1. Reset, core read of 0x100, mem_ready on the first ACCESS cycle with mem_rdata = 0xDEADBEEF
//    -> c_ack at cycle +2, rdata = 0xDEADBEEF, c_err = 0, owner = 0.
// 2. c_req and d_req both held for 4 transactions, 1 wait state each
//    -> grant order C, D, C, D; each ack is 1 cycle; d_ack never overlaps c_ack.
// 3. DMA write of 0x55AA to 0x2000, mem_ready after 3 cycles
//    -> mem_valid high 3 cycles, mem_we = 1, mem_addr = 0x2000, mem_wdata = 0x55AA throughout, d_ack = 1.
// 4. TIMEOUT = 4, core read, mem_ready never asserted
//    -> mem_valid high exactly 4 cycles, then c_ack = 1 with c_err = 1, rdata = 0, FSM back in IDLE.
// 5. rst low during the 2nd ACCESS cycle
//    -> mem_valid = 0 immediately, no ack, busy = 0; after release a pending d_req is granted.
// 6. c_addr changed and c_req dropped mid-ACCESS
//    -> mem_addr keeps the original value, c_ack still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`timescale 1ns/1ps
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter: FSM state encodings and
// the owner identifiers used for the grant / owner signals.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_DMA  = 1'b1;

    // Width of a counter that must hold values 0 .. limit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// mem_port_arbiter_if
// Bundles the two requester ports (core C, DMA D), the shared memory port and
// the arbiter status outputs.
//   slave  : seen by the arbiter (requests and memory response in, acks/bus out)
//   master : seen by the surrounding system (drives requests and memory response)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ack;
    logic              c_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_err;

    logic [DATA_W-1:0] rdata;

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;
    logic              busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output c_ack, c_err, d_ack, d_err, rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        output owner, busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  c_ack, c_err, d_ack, d_err, rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        input  owner, busy
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
`timescale 1ns/1ps
// rr_pick2
// Two-way round-robin pick, purely combinational.
//   req[0]      core request, req[1] DMA request
//   last_grant  id of the previous winner
//   grant_valid any request present
//   grant_id    winner; on a tie the port that did not win last time
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = OWNER_CORE;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = OWNER_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one memory port between the core (C) and a DMA/debug master (D).
// Round-robin grant, one transaction in flight, variable-latency memory
// handshake with an optional wait-state timeout.
// Ports:
//   clk  clock
//   rst  asynchronous, active-low reset
//   bus  mem_port_arbiter_if.slave: request ports C/D with ack/err, shared
//        rdata, memory port (valid/we/addr/wdata/ready/rdata), owner, busy
// Parameters: ADDR_W, DATA_W, TIMEOUT (max ACCESS cycles, 0 = no timeout)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
)(
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);

    localparam int                CNT_W   = cnt_width(TIMEOUT);
    localparam bit                TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t        state_q, state_n;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              owner_q;
    logic              last_grant_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    // Captured transaction; only observed while in ACCESS, so no reset needed.
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic grant_valid;
    logic grant_id;
    logic timeout_hit;
    logic in_access;
    logic in_resp;

    rr_pick2 u_pick (
        .req         ({bus.d_req, bus.c_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        in_access   = 1'b0;
        in_resp     = 1'b0;
        timeout_hit = TO_EN && (wait_cnt_q == TO_LAST);
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_n = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                in_access = 1'b1;
                if (bus.mem_ready || timeout_hit) begin
                    state_n = ARB_RESP;
                end
            end
            ARB_RESP: begin
                in_resp = 1'b1;
                state_n = ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q   <= '0;
            owner_q      <= OWNER_CORE;
            last_grant_q <= OWNER_DMA;   // so the core wins the first tie
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner_q      <= grant_id;
                        last_grant_q <= grant_id;
                    end
                end
                ARB_ACCESS: begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    // mem_ready wins over a timeout landing on the same cycle
                    if (bus.mem_ready) begin
                        rdata_q <= we_q ? '0 : bus.mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    wait_cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ARB_IDLE && grant_valid) begin
            if (grant_id == OWNER_DMA) begin
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end else begin
                we_q    <= bus.c_we;
                addr_q  <= bus.c_addr;
                wdata_q <= bus.c_wdata;
            end
        end
    end

    // Memory bus is forced to zero outside ACCESS so the unreset capture
    // registers never leak onto it.
    assign bus.mem_valid = in_access;
    assign bus.mem_we    = in_access & we_q;
    assign bus.mem_addr  = in_access ? addr_q  : '0;
    assign bus.mem_wdata = in_access ? wdata_q : '0;

    assign bus.c_ack = in_resp & (owner_q == OWNER_CORE);
    assign bus.d_ack = in_resp & (owner_q == OWNER_DMA);
    assign bus.c_err = bus.c_ack & err_q;
    assign bus.d_err = bus.d_ack & err_q;

    assign bus.rdata = rdata_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q != ARB_IDLE);

endmodule
